// File: rtl/t03_timer_scheduler.sv
// Multi-channel one-shot/periodic alarm scheduler over a free-running tick count.
// Expired channels are delivered one at a time, round-robin, over a valid/ack handshake.
module t03_timer_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [CNT_W-1:0]  tick_count,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_arm,
  input  logic              cfg_periodic,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic              irq_valid,
  output logic [CH_W-1:0]   irq_ch,
  output logic [CNT_W-1:0]  irq_time,
  input  logic              irq_ack,
  output logic [NUM_CH-1:0] armed,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  typedef enum logic {IrqIdle, IrqBusy} irq_state_e;

  logic [CNT_W-1:0]  deadline_q [NUM_CH];
  logic [CNT_W-1:0]  deadline_d [NUM_CH];
  logic [CNT_W-1:0]  period_q   [NUM_CH];
  logic [CNT_W-1:0]  period_d   [NUM_CH];
  logic [CNT_W-1:0]  last_dl_q  [NUM_CH];
  logic [CNT_W-1:0]  last_dl_d  [NUM_CH];
  logic [CNT_W-1:0]  diff       [NUM_CH];
  logic [NUM_CH-1:0] periodic_q, periodic_d;
  logic [NUM_CH-1:0] armed_q, armed_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] expire;

  irq_state_e       state_q, state_d;
  logic [CH_W-1:0]  irq_ch_q, irq_ch_d;
  logic [CNT_W-1:0] irq_time_q, irq_time_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CH_W-1:0]  sel, idx;
  logic             found;
  logic             ack_fire;

  // Wrap-safe: at or past the deadline when the modular difference is non-negative.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_expire
    assign diff[g]   = tick_count - deadline_q[g];
    assign expire[g] = armed_q[g] & ~diff[g][CNT_W-1];
  end

  assign ack_fire = (state_q == IrqBusy) && irq_ack;

  always_comb begin
    deadline_d = deadline_q;
    period_d   = period_q;
    last_dl_d  = last_dl_q;
    periodic_d = periodic_q;
    armed_d    = armed_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (expire[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i]) overrun_d[i] = 1'b1;
        last_dl_d[i] = deadline_q[i];
        if (periodic_q[i]) deadline_d[i] = deadline_q[i] + period_q[i];
        else               armed_d[i]    = 1'b0;
      end else if (ack_fire && irq_ch_q == CH_W'(i)) begin
        pending_d[i] = 1'b0;
      end
      // A config write overrides any expiry on the same channel this cycle.
      if (cfg_wr && cfg_ch == CH_W'(i)) begin
        armed_d[i]   = cfg_arm;
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
        if (cfg_arm) begin
          deadline_d[i] = tick_count + cfg_delay;
          period_d[i]   = cfg_period;
          periodic_d[i] = cfg_periodic && (cfg_period != '0);
        end
      end
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr_q + CH_W'(k);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    irq_ch_d   = irq_ch_q;
    irq_time_d = irq_time_q;
    rr_d       = rr_q;
    unique case (state_q)
      IrqIdle: begin
        if (found) begin
          state_d    = IrqBusy;
          irq_ch_d   = sel;
          irq_time_d = last_dl_q[sel];
        end
      end
      IrqBusy: begin
        if (irq_ack) begin
          state_d = IrqIdle;
          rr_d    = irq_ch_q + CH_W'(1);
        end
      end
      default: state_d = IrqIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        deadline_q[i] <= '0;
        period_q[i]   <= '0;
        last_dl_q[i]  <= '0;
      end
      periodic_q <= '0;
      armed_q    <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      state_q    <= IrqIdle;
      irq_ch_q   <= '0;
      irq_time_q <= '0;
      rr_q       <= '0;
    end else begin
      deadline_q <= deadline_d;
      period_q   <= period_d;
      last_dl_q  <= last_dl_d;
      periodic_q <= periodic_d;
      armed_q    <= armed_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
      irq_ch_q   <= irq_ch_d;
      irq_time_q <= irq_time_d;
      rr_q       <= rr_d;
    end
  end

  assign irq_valid = (state_q == IrqBusy);
  assign irq_ch    = irq_ch_q;
  assign irq_time  = irq_time_q;
  assign armed     = armed_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_t03_timer_scheduler.sv
// Bench for t03_timer_scheduler: directed scenarios plus random traffic, every cycle
// compared against a behavioural channel/delivery model.
module tb_t03_timer_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] tick_count;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic        cfg_arm;
  logic        cfg_periodic;
  logic [31:0] cfg_delay;
  logic [31:0] cfg_period;
  logic        irq_valid;
  logic [1:0]  irq_ch;
  logic [31:0] irq_time;
  logic        irq_ack;
  logic [3:0]  armed;
  logic [3:0]  pending;
  logic [3:0]  overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_dl [N];
  logic [31:0] m_per [N];
  logic [31:0] m_last [N];
  logic [3:0]  m_periodic, m_armed, m_pend, m_ovr;
  logic        m_valid;
  int          m_ch, m_rr;
  logic [31:0] m_time;
  bit          tick_run = 1'b1;

  t03_timer_scheduler #(.NUM_CH(4), .CNT_W(32)) dut (
    .clk(clk), .nrst(nrst), .tick_count(tick_count),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_arm(cfg_arm), .cfg_periodic(cfg_periodic),
    .cfg_delay(cfg_delay), .cfg_period(cfg_period),
    .irq_valid(irq_valid), .irq_ch(irq_ch), .irq_time(irq_time), .irq_ack(irq_ack),
    .armed(armed), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_dl[c] = '0; m_per[c] = '0; m_last[c] = '0;
    end
    m_periodic = '0; m_armed = '0; m_pend = '0; m_ovr = '0;
    m_valid = 1'b0; m_ch = 0; m_rr = 0; m_time = '0;
  endtask

  // Applies one clock edge of the alarm rules to the model, using the inputs held at that edge.
  task automatic model_step();
    logic [3:0]  old_pend;
    logic [31:0] old_last [N];
    logic [31:0] d;
    bit          fire;
    int          k;
    old_pend = m_pend;
    for (int c = 0; c < N; c++) old_last[c] = m_last[c];
    for (int c = 0; c < N; c++) begin
      d    = tick_count - m_dl[c];
      fire = m_armed[c] && ($signed(d) >= 0);
      if (fire) begin
        if (m_pend[c]) m_ovr[c] = 1'b1;
        m_pend[c] = 1'b1;
        m_last[c] = m_dl[c];
        if (m_periodic[c]) m_dl[c] = m_dl[c] + m_per[c];
        else               m_armed[c] = 1'b0;
      end else if (m_valid && irq_ack && m_ch == c) begin
        m_pend[c] = 1'b0;
      end
      if (cfg_wr && int'(cfg_ch) == c) begin
        m_armed[c] = cfg_arm;
        m_pend[c]  = 1'b0;
        m_ovr[c]   = 1'b0;
        if (cfg_arm) begin
          m_dl[c]       = tick_count + cfg_delay;
          m_per[c]      = cfg_period;
          m_periodic[c] = cfg_periodic && (cfg_period != 0);
        end
      end
    end
    if (m_valid) begin
      if (irq_ack) begin
        m_valid = 1'b0;
        m_rr    = (m_ch + 1) % N;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        k = (m_rr + j) % N;
        if (old_pend[k]) begin
          m_valid = 1'b1;
          m_ch    = k;
          m_time  = old_last[k];
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("irq_valid", 64'(irq_valid), 64'(m_valid));
    check("armed", 64'(armed), 64'(m_armed));
    check("pending", 64'(pending), 64'(m_pend));
    check("overrun", 64'(overrun), 64'(m_ovr));
    if (m_valid) begin
      check("irq_ch", 64'(irq_ch), 64'(m_ch));
      check("irq_time", 64'(irq_time), 64'(m_time));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (tick_run) tick_count = tick_count + 1;
    cfg_wr  = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input bit arm, input bit per,
                           input logic [31:0] dly, input logic [31:0] prd);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_arm = arm; cfg_periodic = per;
    cfg_delay = dly; cfg_period = prd;
    step();
  endtask

  task automatic wait_irq(input int budget);
    int n;
    n = 0;
    while (!irq_valid && n < budget) begin
      step();
      n++;
    end
    if (!irq_valid) check("irq_timeout", 64'(0), 64'(1));
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    step();
  endtask

  task automatic quiesce();
    for (int c = 0; c < N; c++) write_cfg(c, 1'b0, 1'b0, 0, 0);
    if (irq_valid) ack_irq();
    step();
  endtask

  initial begin
    nrst = 1'b0; tick_count = 32'd0; cfg_wr = 1'b0; cfg_ch = '0; cfg_arm = 1'b0;
    cfg_periodic = 1'b0; cfg_delay = '0; cfg_period = '0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq_valid", 64'(irq_valid), 64'(0));
    check("rst_irq_ch", 64'(irq_ch), 64'(0));
    check("rst_irq_time", 64'(irq_time), 64'(0));
    check("rst_flags", 64'({armed, pending, overrun}), 64'(0));
    nrst = 1'b1;

    // One-shot at tick 100, delay 5
    tick_count = 32'd100;
    write_cfg(1, 1'b1, 1'b0, 5, 0);
    wait_irq(20);
    check("t1_ch", 64'(irq_ch), 64'(1));
    check("t1_time", 64'(irq_time), 64'(105));
    ack_irq();
    check("t1_armed", 64'(armed[1]), 64'(0));
    check("t1_pending", 64'(pending[1]), 64'(0));

    // Periodic delay 2 period 3 from tick 10
    tick_count = 32'd10;
    write_cfg(0, 1'b1, 1'b1, 2, 3);
    for (int i = 0; i < 4; i++) begin
      wait_irq(20);
      check("t2_time", 64'(irq_time), 64'(12 + 3 * i));
      ack_irq();
    end
    repeat (8) step();
    check("t2_overrun", 64'(overrun[0]), 64'(1));
    quiesce();

    // Round robin: ack ch1 first so the pointer sits at 2
    write_cfg(1, 1'b1, 1'b0, 0, 0);
    wait_irq(10);
    ack_irq();
    write_cfg(0, 1'b1, 1'b0, 10, 0);
    write_cfg(2, 1'b1, 1'b0, 9, 0);
    write_cfg(3, 1'b1, 1'b0, 8, 0);
    wait_irq(20);
    check("t3_first", 64'(irq_ch), 64'(2));
    ack_irq();
    check("t3_gap", 64'(irq_valid), 64'(0));
    step();
    check("t3_second", 64'(irq_ch), 64'(3));
    ack_irq();
    check("t3_gap2", 64'(irq_valid), 64'(0));
    step();
    check("t3_third", 64'(irq_ch), 64'(0));
    ack_irq();

    // Counter wrap
    tick_count = 32'hFFFF_FFFE;
    write_cfg(2, 1'b1, 1'b0, 4, 0);
    repeat (3) begin
      step();
      check("t4_early", 64'(irq_valid), 64'(0));
    end
    wait_irq(10);
    check("t4_ch", 64'(irq_ch), 64'(2));
    check("t4_time", 64'(irq_time), 64'(2));
    ack_irq();

    // Disarm on the expiry cycle, then disarm while presented
    write_cfg(1, 1'b1, 1'b0, 3, 0);
    step();
    step();
    write_cfg(1, 1'b0, 1'b0, 0, 0);
    check("t5_pending", 64'(pending[1]), 64'(0));
    repeat (3) begin
      step();
      check("t5_noirq", 64'(irq_valid), 64'(0));
    end
    write_cfg(1, 1'b1, 1'b0, 0, 0);
    wait_irq(10);
    write_cfg(1, 1'b0, 1'b0, 0, 0);
    check("t5_held", 64'(irq_valid), 64'(1));
    check("t5_held_ch", 64'(irq_ch), 64'(1));
    ack_irq();
    step();

    // Reset mid-presentation
    write_cfg(3, 1'b1, 1'b0, 0, 0);
    write_cfg(0, 1'b1, 1'b1, 1, 2);
    wait_irq(10);
    #2 nrst = 1'b0;
    #1;
    check("t6_valid", 64'(irq_valid), 64'(0));
    check("t6_flags", 64'({armed, pending, overrun}), 64'(0));
    model_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
    repeat (5) begin
      step();
      check("t6_quiet", 64'(irq_valid), 64'(0));
    end

    // Random traffic, starting close to the wrap point
    tick_count = 32'hFFFF_FF00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick_run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr       = 1'b1;
        cfg_ch       = 2'($urandom_range(0, 3));
        cfg_arm      = ($urandom_range(0, 3) != 0);
        cfg_periodic = 1'($urandom_range(0, 1));
        cfg_delay    = 32'($urandom_range(0, 20));
        cfg_period   = 32'($urandom_range(0, 12));
      end
      irq_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    tick_run = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
